// File: rtl/ram_pkg.sv
// Shared types and default geometry for the scrubbing single-port RAM.
package ram_pkg;

  localparam int RAM_N_DEF = 8;
  localparam int RAM_A_DEF = 10;

  typedef enum logic [0:0] {
    ST_SCRUB = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/ram_scrub_ctl.sv
// Scrub sequencer: walks every word address once after reset or a CLR request.
module ram_scrub_ctl
  import ram_pkg::*;
#(
  parameter int A = RAM_A_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  output logic         scrub_we,
  output logic [A-1:0] scrub_addr,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [A-1:0] cnt_q, cnt_d;

  // State and scrub counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SCRUB;
      cnt_q   <= {A{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: CLR is only honoured from idle, so a running scrub never restarts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SCRUB: begin
        cnt_d = cnt_q + A'(1);
        if (cnt_q == {A{1'b1}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SCRUB;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_SCRUB;
          cnt_d   = {A{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_SCRUB;
        cnt_d   = {A{1'b0}};
      end
    endcase
  end

  // Outputs are pure decodes of state
  always_comb begin
    busy       = (state_q == ST_SCRUB);
    scrub_we   = (state_q == ST_SCRUB);
    scrub_addr = cnt_q;
  end

endmodule

// File: rtl/ram_sp_scrub.sv
// Single-port synchronous RAM with registered read data and a built-in fill scrubber.
module ram_sp_scrub
  import ram_pkg::*;
#(
  parameter int           N    = RAM_N_DEF,
  parameter int           A    = RAM_A_DEF,
  parameter logic [N-1:0] FILL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         CS,
  input  logic         EN,
  input  logic         RWS,
  input  logic [A-1:0] ADDR,
  input  logic [N-1:0] DIN,
  input  logic         CLR,
  output logic [N-1:0] DOUT,
  output logic         DVALID,
  output logic         BUSY,
  output logic         REJ
);

  localparam int DEPTH = 2 ** A;

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] dout_q, dout_d;
  logic         dvalid_q, dvalid_d;
  logic         rej_q, rej_d;

  logic         scrub_we_s;
  logic [A-1:0] scrub_addr_s;
  logic         busy_s;
  logic         req_s;
  logic         acc_ok_s;
  logic         we_s;
  logic [A-1:0] waddr_s;
  logic [N-1:0] wdata_s;

  ram_scrub_ctl #(
    .A(A)
  ) u_ctl (
    .clk       (clk),
    .rst       (rst),
    .clr       (CLR),
    .scrub_we  (scrub_we_s),
    .scrub_addr(scrub_addr_s),
    .busy      (busy_s)
  );

  // Request gating and write-port mux; a CLR cycle swallows any user access
  always_comb begin
    req_s    = CS & EN;
    acc_ok_s = req_s & ~busy_s & ~CLR;
    waddr_s  = ADDR;
    wdata_s  = DIN;
    if (rst) begin
      we_s = 1'b0;
    end else if (scrub_we_s) begin
      we_s    = 1'b1;
      waddr_s = scrub_addr_s;
      wdata_s = FILL;
    end else if (acc_ok_s & RWS) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Read data, valid pulse and reject pulse next-values
  always_comb begin
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    rej_d    = req_s & (busy_s | CLR);
    if (acc_ok_s & ~RWS) begin
      dout_d   = mem_q[ADDR];
      dvalid_d = 1'b1;
    end else begin
      dvalid_d = 1'b0;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= {N{1'b0}};
      dvalid_q <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      rej_q    <= rej_d;
    end
  end

  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign REJ    = rej_q;
  assign BUSY   = busy_s;

endmodule
